nibble_cpu_core: RTL and testbench

//  Parametrised multi-cycle CPU over a shared narrow bus. Fetches 3-nibble instructions,

---
 rtl/nibble_cpu_pkg.sv | 34 +++
 rtl/nibble_alu.sv | 33 +++
 rtl/nibble_cpu_core.sv | 147 ++++++++++++++
 tb/tb_nibble_cpu_core.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_cpu_pkg.sv
// Shared constants for the nibble CPU: opcodes, bus cycle kinds, FSM state codes.
package nibble_cpu_pkg;

  // F1 opcode field (low four bits of the fetched field)
  localparam logic [3:0] OP_LD  = 4'd0;
  localparam logic [3:0] OP_ST  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_BNZ = 4'd6;
  localparam logic [3:0] OP_HLT = 4'd15;

  // bus_kind codes
  localparam logic [2:0] BK_F1    = 3'd0;
  localparam logic [2:0] BK_F2    = 3'd1;
  localparam logic [2:0] BK_F3    = 3'd2;
  localparam logic [2:0] BK_LOAD  = 3'd3;
  localparam logic [2:0] BK_STORE = 3'd4;
  localparam logic [2:0] BK_IDLE  = 3'd7;

  // one-hot FSM states
  localparam logic [4:0] S_F1   = 5'b00001;
  localparam logic [4:0] S_F2   = 5'b00010;
  localparam logic [4:0] S_F3   = 5'b00100;
  localparam logic [4:0] S_MEM  = 5'b01000;
  localparam logic [4:0] S_HALT = 5'b10000;

  // ops that write a register from an operand (immediate or memory)
  function automatic logic is_ld_alu(input logic [3:0] op);
    return (op == OP_LD) || (op >= OP_ADD && op <= OP_XOR);
  endfunction

endpackage

// File: rtl/nibble_alu.sv
// Combinational ALU: LD passes b through, ADD gives carry-out, logic ops leave carry 0.
module nibble_alu
  import nibble_cpu_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  logic [DATA_W:0] sum;
  assign sum = {1'b0, a} + {1'b0, b};

  // operation select; anything that is not an ALU op behaves as a pass-through
  always_comb begin
    result = b;
    carry  = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      default: ;
    endcase
  end

endmodule

// File: rtl/nibble_cpu_core.sv
// Multi-cycle nibble CPU: three fetch cycles per instruction plus an optional
// memory cycle, all over one shared bus with a ready/wait handshake.
// Opcode and F2 fields use the low four bits of the bus data (DATA_W >= 4).
module nibble_cpu_core
  import nibble_cpu_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int PC_W   = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [PC_W-1:0]   bus_addr,
  output logic [2:0]        bus_kind,
  output logic              bus_we,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ready,
  output logic              halted,
  output logic              flag_c,
  output logic [DATA_W-1:0] dbg_a,
  output logic [DATA_W-1:0] dbg_x,
  output logic [DATA_W-1:0] dbg_y
);

  logic [4:0]               state_q;
  logic [PC_W-1:0]          pc_q;
  logic [3:0]               op_q;
  logic [3:0]               f2_q;
  logic [DATA_W-1:0]        maddr_q;
  logic [2:0][DATA_W-1:0]   rf_q;     // 0 A, 1 X, 2 Y
  logic                     c_q;

  logic [1:0]               r_sel;
  logic                     imm;
  logic                     idx;
  logic [DATA_W-1:0]        r_val;
  logic [DATA_W-1:0]        alu_res;
  logic                     alu_c;
  logic                     wr_en;
  logic [PC_W-1:0]          pc_inc;
  logic [PC_W-1:0]          k_sext;
  logic [DATA_W-1:0]        maddr_d;

  assign r_sel = f2_q[1:0];
  assign imm   = f2_q[2];
  assign idx   = f2_q[3];

  // register read port; r=3 is "no register" and reads as zero
  always_comb begin
    case (r_sel)
      2'd0:    r_val = rf_q[0];
      2'd1:    r_val = rf_q[1];
      2'd2:    r_val = rf_q[2];
      default: r_val = '0;
    endcase
  end

  // the operand is always whatever is on the bus: k in F3, memory data in MEM
  nibble_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (op_q),
    .a      (r_val),
    .b      (bus_rdata),
    .result (alu_res),
    .carry  (alu_c)
  );

  assign wr_en   = ((state_q == S_F3) && imm && is_ld_alu(op_q)) ||
                   ((state_q == S_MEM) && (op_q != OP_ST));
  assign pc_inc  = pc_q + PC_W'(1);
  assign k_sext  = {{(PC_W-DATA_W){bus_rdata[DATA_W-1]}}, bus_rdata};
  // X sampled here is the pre-instruction value; nothing writes X before MEM
  assign maddr_d = bus_rdata + (idx ? rf_q[1] : '0);

  // FSM, PC and register file; a low bus_ready freezes everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_F1;
      pc_q    <= '0;
      op_q    <= '0;
      f2_q    <= '0;
      maddr_q <= '0;
      rf_q    <= '0;
      c_q     <= 1'b0;
    end else if (bus_ready) begin
      if (wr_en) begin
        for (int i = 0; i < 3; i++)
          if (r_sel == i[1:0]) rf_q[i] <= alu_res;
        if (op_q == OP_ADD) c_q <= alu_c;
      end
      case (state_q)
        S_F1: begin
          op_q    <= bus_rdata[3:0];
          state_q <= S_F2;
        end
        S_F2: begin
          f2_q    <= bus_rdata[3:0];
          state_q <= S_F3;
        end
        S_F3: begin
          pc_q    <= pc_inc;
          maddr_q <= maddr_d;
          state_q <= S_F1;
          if (op_q == OP_HLT)
            state_q <= S_HALT;
          else if (op_q == OP_BNZ) begin
            if (r_val != '0) pc_q <= pc_inc + k_sext;
          end else if (!imm && (is_ld_alu(op_q) || op_q == OP_ST))
            state_q <= S_MEM;
        end
        S_MEM:   state_q <= S_F1;
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_F1;
      endcase
    end
  end

  // bus outputs are a pure function of held state, so they stay frozen in waits
  always_comb begin
    bus_addr  = pc_q;
    bus_kind  = BK_F1;
    bus_we    = 1'b0;
    bus_wdata = '0;
    case (state_q)
      S_F2: bus_kind = BK_F2;
      S_F3: bus_kind = BK_F3;
      S_MEM: begin
        bus_addr = {{(PC_W-DATA_W){1'b0}}, maddr_q};
        if (op_q == OP_ST) begin
          bus_kind  = BK_STORE;
          bus_we    = 1'b1;
          bus_wdata = r_val;
        end else begin
          bus_kind  = BK_LOAD;
        end
      end
      S_HALT:  bus_kind = BK_IDLE;
      default: ;
    endcase
  end

  assign halted = (state_q == S_HALT);
  assign flag_c = c_q;
  assign dbg_a  = rf_q[0];
  assign dbg_x  = rf_q[1];
  assign dbg_y  = rf_q[2];

endmodule

// File: tb/tb_nibble_cpu_core.sv
// Bench for nibble_cpu_core: instruction-level reference model plus a memory
// responder; directed programs followed by a random program with random waits.
module tb_nibble_cpu_core;
  localparam int DW = 4;
  localparam int PW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [PW-1:0] bus_addr;
  logic [2:0]    bus_kind;
  logic          bus_we;
  logic [DW-1:0] bus_wdata;
  logic [DW-1:0] bus_rdata;
  logic          bus_ready;
  logic          halted;
  logic          flag_c;
  logic [DW-1:0] dbg_a, dbg_x, dbg_y;

  always #5 clk = ~clk;

  nibble_cpu_core #(.DATA_W(DW), .PC_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .bus_addr(bus_addr), .bus_kind(bus_kind),
    .bus_we(bus_we), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_ready(bus_ready), .halted(halted), .flag_c(flag_c),
    .dbg_a(dbg_a), .dbg_x(dbg_x), .dbg_y(dbg_y)
  );

  logic [11:0] prog [1024];   // {op, f2, k} per instruction index
  logic [3:0]  dmem [16];
  int m_pc, m_c, m_h;
  int m_r [4];
  int e_kind [4], e_addr [4], e_we [4], e_wd [4], e_n;
  int n_chk = 0, n_err = 0;
  int cyc = 0, t0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_c = 0; m_h = 0;
    for (int i = 0; i < 4; i++) m_r[i] = 0;
  endtask

  // executes one whole instruction and lists the bus cycles it should show
  task automatic model_insn();
    logic [11:0] ins;
    int op, f2, k, r, imm, idx, rv, addr, opd, res, sk;
    ins = prog[m_pc];
    op = int'(ins[11:8]); f2 = int'(ins[7:4]); k = int'(ins[3:0]);
    r = f2 % 4; imm = (f2 >> 2) & 1; idx = (f2 >> 3) & 1;
    rv = (r == 3) ? 0 : m_r[r];
    addr = (k + (idx != 0 ? m_r[1] : 0)) % 16;
    for (int i = 0; i < 4; i++) begin
      e_kind[i] = i; e_addr[i] = m_pc; e_we[i] = 0; e_wd[i] = 0;
    end
    e_n = 3;
    m_pc = (m_pc + 1) % 1024;
    if (op == 15) m_h = 1;
    else if (op == 6) begin
      sk = (k >= 8) ? k - 16 : k;
      if (rv != 0) m_pc = (m_pc + sk + 1024) % 1024;
    end else if (op == 1) begin
      if (imm == 0) begin
        e_n = 4; e_kind[3] = 4; e_addr[3] = addr; e_we[3] = 1; e_wd[3] = rv;
        dmem[addr] = rv[3:0];
      end
    end else if (op == 0 || (op >= 2 && op <= 5)) begin
      opd = k;
      if (imm == 0) begin
        e_n = 4; e_kind[3] = 3; e_addr[3] = addr;
        opd = int'(dmem[addr]);
      end
      res = opd;
      case (op)
        2: begin res = rv + opd; m_c = res / 16; res = res % 16; end
        3: res = rv & opd;
        4: res = rv | opd;
        5: res = rv ^ opd;
        default: ;
      endcase
      if (r != 3) m_r[r] = res;
    end
  endtask

  function automatic logic [3:0] resp();
    logic [11:0] w;
    w = prog[bus_addr];
    case (bus_kind)
      3'd0:    return w[11:8];
      3'd1:    return w[7:4];
      3'd2:    return w[3:0];
      3'd3:    return dmem[bus_addr[3:0]];
      default: return 4'd0;
    endcase
  endfunction

  // wmode 0: no waits; 1: random waits; 2: three waits in F2 and in MEM
  task automatic run_insns(input int n, input int wmode);
    int nw;
    for (int i = 0; i < n; i++) begin
      if (m_h != 0) break;
      model_insn();
      for (int c = 0; c < e_n; c++) begin
        nw = 0;
        if (wmode == 2 && (c == 1 || c == 3)) nw = 3;
        else if (wmode == 1 && $urandom_range(0, 3) == 0) nw = $urandom_range(1, 3);
        for (int w = 0; w <= nw; w++) begin
          @(negedge clk);
          bus_ready = (w == nw);
          bus_rdata = (w == nw) ? resp() : 4'($urandom);
          chk("kind", bus_kind, e_kind[c]);
          chk("addr", bus_addr, e_addr[c]);
          chk("we", bus_we, e_we[c]);
          chk("wdata", bus_wdata, e_wd[c]);
        end
      end
      @(posedge clk); #1;
      chk("a", dbg_a, m_r[0]);
      chk("x", dbg_x, m_r[1]);
      chk("y", dbg_y, m_r[2]);
      chk("c", flag_c, m_c);
      chk("halted", halted, m_h);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; bus_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_kind"}, bus_kind, 0);
    chk({tag, "_addr"}, bus_addr, 0);
    chk({tag, "_we"}, bus_we, 0);
    chk({tag, "_wdata"}, bus_wdata, 0);
    chk({tag, "_a"}, dbg_a, 0);
    chk({tag, "_x"}, dbg_x, 0);
    chk({tag, "_y"}, dbg_y, 0);
    chk({tag, "_c"}, flag_c, 0);
    chk({tag, "_halted"}, halted, 0);
  endtask

  initial begin
    rst_n = 1'b0; bus_ready = 1'b1; bus_rdata = '0;
    for (int i = 0; i < 1024; i++) prog[i] = 12'h700;
    for (int i = 0; i < 16; i++) dmem[i] = 4'd0;
    model_reset();
    #1 check_reset("rst0");

    // LD A,#5 ; ADD A,#C
    prog[0] = 12'h045; prog[1] = 12'h24C;
    do_reset(); t0 = cyc;
    run_insns(2, 0);
    chk("t1_cyc", cyc - t0, 6);
    chk("t1_a", dbg_a, 1);
    chk("t1_c", flag_c, 1);
    chk("t1_pc", bus_addr, 2);

    // LD X,#1 ; LD Y,[2+X] with mem[3]=9
    dmem[3] = 4'd9;
    prog[0] = 12'h051; prog[1] = 12'h0A2;
    do_reset(); run_insns(2, 0);
    chk("t2_y", dbg_y, 9);

    // LD A,#7 ; ST A,[6]
    prog[0] = 12'h047; prog[1] = 12'h106;
    do_reset(); run_insns(2, 0);
    chk("t3_a", dbg_a, 7);
    chk("t3_mem", dmem[6], 7);

    // BNZ X,#E at PC 5: taken with X=2, not taken with X=0
    prog[0] = 12'h052; prog[5] = 12'h61E;
    do_reset(); run_insns(6, 0);
    chk("t4_taken_pc", bus_addr, 4);
    prog[0] = 12'h050;
    do_reset(); run_insns(6, 0);
    chk("t4_fall_pc", bus_addr, 6);

    // three-cycle waits in F2 and MEM: LD A,#3 ; ADD A,[5] with mem[5]=6
    dmem[5] = 4'd6;
    prog[0] = 12'h043; prog[1] = 12'h205;
    do_reset(); t0 = cyc;
    run_insns(2, 2);
    chk("t5_cyc", cyc - t0, 16);
    chk("t5_a", dbg_a, 9);
    chk("t5_pc", bus_addr, 2);

    // halt holds idle, then a reset in the middle of F2 of a later run
    prog[0] = 12'h049; prog[1] = 12'h053; prog[2] = 12'hF00;
    do_reset(); run_insns(3, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus_ready = 1'($urandom_range(0, 1));
      bus_rdata = 4'($urandom);
      chk("t6_halted", halted, 1);
      chk("t6_kind", bus_kind, 7);
    end
    do_reset(); run_insns(1, 0);
    chk("t6_a_pre", dbg_a, 9);
    @(negedge clk); bus_ready = 1'b1; bus_rdata = resp();
    @(negedge clk);
    chk("t6_in_f2", bus_kind, 1);
    rst_n = 1'b0;
    #1 check_reset("t6_rst");
    @(posedge clk); #1 rst_n = 1'b1;
    model_reset();

    // random program (no HLT) with random wait states
    for (int i = 0; i < 1024; i++) begin
      prog[i] = 12'($urandom);
      if (prog[i][11:8] == 4'hF) prog[i][11:8] = 4'h7;
    end
    for (int i = 0; i < 16; i++) dmem[i] = 4'($urandom);
    do_reset(); run_insns(250, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
